stage_fetch: RTL and testbench

Instruction fetch stage of the 5-stage in-order RV32I pipeline. Holds the architectural PC and issues one 32-bit instruction fetch per cycle to a 1-cycle-latency instruction memory. Delivers `instr_o` and the `if_id_reg_t` pipeline register to the decode stage. Accepts JAL/JALR/branch redirects that decode resolves combinationally.

---
 rtl/stage_fetch_if.sv | 33 +++
 rtl/stage_fetch.sv | 141 ++++++++++++++
 tb/tb_stage_fetch.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_fetch_if.sv
// Instruction-memory bus for the fetch stage, plus the IF-ID register type.
// master: fetch stage (drives request/address); slave: instruction memory.
package stage_fetch_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc_plus_four;
   } if_id_reg_t;
endpackage

interface stage_fetch_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/stage_fetch.sv
// RV32I instruction fetch stage: holds the PC, issues one fetch per cycle to a
// 1-cycle-latency instruction memory and fills the IF-ID register.
// Optional feature: define FETCH_MISALIGN_CHK_EN to flag misaligned redirect
// targets (sticky fetch_misalign_o, fetching halts); otherwise targets are
// silently word-aligned.
module stage_fetch
   import stage_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst_i,
   input  logic                stall_i,
   input  logic                instr_jal_i,
   input  logic                instr_jalr_i,
   input  logic                branch_taken_i,
   input  logic [31:0]         jal_addr_i,
   input  logic [31:0]         jalr_addr_i,
   input  logic [31:0]         branch_addr_i,
   stage_fetch_if.master       imem,
   output logic [31:0]         instr_o,
`ifdef FETCH_MISALIGN_CHK_EN
   output if_id_reg_t          if_id_o,
   output logic                fetch_misalign_o
`else
   output if_id_reg_t          if_id_o
`endif
);

   typedef enum logic {BOOT, RUN} state_t;

   state_t      state_r, state_nxt;
   logic [31:0] pc_r;
   if_id_reg_t  if_id_r;
   logic        outstanding_r;
   logic [31:0] hold_r;
   logic        hold_valid_r;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] target_ld;
   logic        halted;
   logic        req;
   logic        accept;
   logic        advance;

   // Redirect detection and target selection, JALR > JAL > branch.
   always_comb begin
      redirect = instr_jalr_i | instr_jal_i | branch_taken_i;
      if (instr_jalr_i)     target = jalr_addr_i;
      else if (instr_jal_i) target = jal_addr_i;
      else                  target = branch_addr_i;
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_r;

   assign target_ld        = target;
   assign halted           = misalign_r;
   assign fetch_misalign_o = misalign_r;

   // Sticky misalignment flag, set by a misaligned redirect target.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i)
         misalign_r <= 1'b0;
      else if (advance && !misalign_r && redirect && (target[1:0] != 2'b00))
         misalign_r <= 1'b1;
   end
`else
   assign target_ld = target & ~32'd3;
   assign halted    = 1'b0;
`endif

   // Boot/run sequencing and the fetch request.
   always_comb begin
      state_nxt = state_r;
      req       = 1'b0;
      case (state_r)
         BOOT:    state_nxt = RUN;
         RUN:     req = !stall_i && !redirect && !halted;
         default: state_nxt = BOOT;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) state_r <= BOOT;
      else       state_r <= state_nxt;
   end

   assign imem.imem_req_o  = req;
   assign imem.imem_addr_o = pc_r;
   assign accept           = req & imem.imem_gnt_i;
   assign advance          = (state_r == RUN) && !stall_i;

   // PC and IF-ID register: redirect squashes, accept advances, no grant bubbles.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         pc_r    <= RESET_PC;
         if_id_r <= '0;
      end else if (advance) begin
         if (halted) begin
            if_id_r.valid <= 1'b0;
         end else if (redirect) begin
            pc_r          <= target_ld;
            if_id_r.valid <= 1'b0;
         end else if (accept) begin
            if_id_r.valid        <= 1'b1;
            if_id_r.pc           <= pc_r;
            if_id_r.pc_plus_four <= pc_r + 32'd4;
            pc_r                 <= pc_r + 32'd4;
         end else begin
            if_id_r.valid <= 1'b0;
         end
      end
   end

   // Tracks an accepted request whose read data has not yet returned.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i)                   outstanding_r <= 1'b0;
      else if (accept)             outstanding_r <= 1'b1;
      else if (imem.imem_rvalid_i) outstanding_r <= 1'b0;
   end

   // Skid register: keeps a response that lands while decode is stalled.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         hold_r       <= '0;
         hold_valid_r <= 1'b0;
      end else if (imem.imem_rvalid_i && outstanding_r && stall_i) begin
         hold_r       <= imem.imem_rdata_i;
         hold_valid_r <= 1'b1;
      end else if (!stall_i) begin
         hold_valid_r <= 1'b0;
      end
   end

   assign instr_o = hold_valid_r ? hold_r : imem.imem_rdata_i;
   assign if_id_o = if_id_r;

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed scenarios plus a randomized
// run against a behavioural PC/IF-ID model with a 1-cycle memory responder.
module tb_stage_fetch;
   import stage_fetch_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        instr_jal_i, instr_jalr_i, branch_taken_i;
   logic [31:0] jal_addr_i, jalr_addr_i, branch_addr_i;
   logic [31:0] instr_o;
   if_id_reg_t  if_id;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        fetch_misalign_o;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   stage_fetch_if bus();

   stage_fetch #(.RESET_PC(RPC)) dut (
      .clk            (clk),
      .rst_i          (rst_i),
      .stall_i        (stall_i),
      .instr_jal_i    (instr_jal_i),
      .instr_jalr_i   (instr_jalr_i),
      .branch_taken_i (branch_taken_i),
      .jal_addr_i     (jal_addr_i),
      .jalr_addr_i    (jalr_addr_i),
      .branch_addr_i  (branch_addr_i),
      .imem           (bus),
      .instr_o        (instr_o),
`ifdef FETCH_MISALIGN_CHK_EN
      .if_id_o        (if_id),
      .fetch_misalign_o (fetch_misalign_o)
`else
      .if_id_o        (if_id)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
   endfunction

   // Advance one clock; the memory answers an accepted request one cycle later.
   task automatic step();
      logic        acc;
      logic [31:0] a;
      acc = bus.imem_req_o && bus.imem_gnt_i;
      a   = bus.imem_addr_o;
      @(posedge clk);
      #1;
      bus.imem_rvalid_i = acc;
      bus.imem_rdata_i  = acc ? memw(a) : $urandom;
   endtask

   task automatic clear_redirects();
      instr_jal_i = 1'b0; instr_jalr_i = 1'b0; branch_taken_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; stall_i = 1'b0; clear_redirects();
      jal_addr_i = '0; jalr_addr_i = '0; branch_addr_i = '0;
      bus.imem_gnt_i = 1'b1; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", bus.imem_req_o); end
      checks++; if (bus.imem_addr_o !== RPC) begin errors++; $display("FAIL reset_addr: got %h expected %h", bus.imem_addr_o, RPC); end
      checks++; if (if_id !== '0) begin errors++; $display("FAIL reset_if_id: got %h expected 0", if_id); end
`ifdef FETCH_MISALIGN_CHK_EN
      checks++; if (fetch_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0b expected 0", fetch_misalign_o); end
`endif
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL boot_req: got %0b expected 0", bus.imem_req_o); end
      step();
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL seq_req%0d: got %0b expected 1", i, bus.imem_req_o); end
         checks++; if (bus.imem_addr_o !== RPC + 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h expected %h", i, bus.imem_addr_o, RPC + 32'(4 * i)); end
         if (i > 0) begin
            checks++; if (if_id.valid !== 1'b1 || if_id.pc !== RPC + 32'(4 * (i - 1)) || if_id.pc_plus_four !== RPC + 32'(4 * i))
               begin errors++; $display("FAIL seq_if_id%0d: got %h expected valid pc=%h", i, if_id, RPC + 32'(4 * (i - 1))); end
            checks++; if (instr_o !== memw(RPC + 32'(4 * (i - 1)))) begin errors++; $display("FAIL seq_instr%0d: got %h expected %h", i, instr_o, memw(RPC + 32'(4 * (i - 1)))); end
         end
         step();
      end
   endtask

   task automatic test_branch();
      branch_taken_i = 1'b1; branch_addr_i = 32'h200;
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL br_req: got %0b expected 0", bus.imem_req_o); end
      step();
      clear_redirects();
      @(negedge clk);
      checks++; if (if_id.valid !== 1'b0) begin errors++; $display("FAIL br_bubble: got %0b expected 0", if_id.valid); end
      checks++; if (bus.imem_addr_o !== 32'h200 || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL br_target: got req=%0b addr=%h expected req=1 addr=200", bus.imem_req_o, bus.imem_addr_o); end
      step();
      @(negedge clk);
      checks++; if (if_id.valid !== 1'b1 || if_id.pc !== 32'h200) begin errors++; $display("FAIL br_decode: got %h expected pc=200 valid", if_id); end
      checks++; if (instr_o !== memw(32'h200)) begin errors++; $display("FAIL br_instr: got %h expected %h", instr_o, memw(32'h200)); end
      step();
   endtask

   task automatic test_simultaneous();
      instr_jalr_i = 1'b1; instr_jal_i = 1'b1; branch_taken_i = 1'b1;
      jalr_addr_i = 32'h300; jal_addr_i = 32'h400; branch_addr_i = 32'h500;
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL sim_req: got %0b expected 0", bus.imem_req_o); end
      step();
      clear_redirects();
      @(negedge clk);
      checks++; if (bus.imem_addr_o !== 32'h300) begin errors++; $display("FAIL sim_prio: got %h expected 300", bus.imem_addr_o); end
      step();
   endtask

   task automatic test_stall();
      stall_i = 1'b1;
      bus.imem_rdata_i = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (instr_o !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_instr%0d: got %h expected deadbeef", i, instr_o); end
         checks++; if (if_id.valid !== 1'b1 || if_id.pc !== 32'h300) begin errors++; $display("FAIL stall_if_id%0d: got %h expected pc=300 valid", i, if_id); end
         checks++; if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h304) begin errors++; $display("FAIL stall_req%0d: got req=%0b addr=%h expected req=0 addr=304", i, bus.imem_req_o, bus.imem_addr_o); end
         step();
         bus.imem_rdata_i = '0;
      end
      stall_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h304) begin errors++; $display("FAIL stall_resume: got req=%0b addr=%h expected req=1 addr=304", bus.imem_req_o, bus.imem_addr_o); end
      checks++; if (instr_o !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_release_instr: got %h expected deadbeef", instr_o); end
      step();
      @(negedge clk);
      checks++; if (if_id.pc !== 32'h304 || instr_o !== memw(32'h304)) begin errors++; $display("FAIL stall_next: got pc=%h instr=%h expected pc=304 instr=%h", if_id.pc, instr_o, memw(32'h304)); end
      step();
   endtask

   task automatic test_gnt_wrap();
      bus.imem_gnt_i = 1'b0;
      step();
      @(negedge clk);
      checks++; if (if_id.valid !== 1'b0 || bus.imem_addr_o !== 32'h30C) begin errors++; $display("FAIL gnt_bubble1: got valid=%0b addr=%h expected valid=0 addr=30c", if_id.valid, bus.imem_addr_o); end
      step();
      bus.imem_gnt_i = 1'b1;
      @(negedge clk);
      checks++; if (if_id.valid !== 1'b0 || bus.imem_addr_o !== 32'h30C || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL gnt_bubble2: got valid=%0b req=%0b addr=%h expected valid=0 req=1 addr=30c", if_id.valid, bus.imem_req_o, bus.imem_addr_o); end
      step();
      @(negedge clk);
      checks++; if (if_id.valid !== 1'b1 || if_id.pc !== 32'h30C) begin errors++; $display("FAIL gnt_retry: got %h expected pc=30c valid", if_id); end
      step();
      instr_jal_i = 1'b1; jal_addr_i = 32'hFFFF_FFFC;
      step();
      clear_redirects();
      @(negedge clk);
      checks++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h expected fffffffc", bus.imem_addr_o); end
      step();
      @(negedge clk);
      checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", bus.imem_addr_o); end
      checks++; if (if_id.pc !== 32'hFFFF_FFFC || if_id.pc_plus_four !== 32'h0) begin errors++; $display("FAIL wrap_if_id: got %h expected pc=fffffffc pc4=0", if_id); end
      step();
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL mid_pre_req: got %0b expected 1", bus.imem_req_o); end
      step();
      #1 rst_i = 1'b1;
      #1;
      checks++; if (if_id.valid !== 1'b0 || bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== RPC) begin errors++; $display("FAIL mid_async: got valid=%0b req=%0b addr=%h expected 0 0 %h", if_id.valid, bus.imem_req_o, bus.imem_addr_o, RPC); end
      bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hBAD0_0BAD;
      @(posedge clk); #1;
      rst_i = 1'b0; stall_i = 1'b1;
      @(negedge clk);
      checks++; if (if_id.valid !== 1'b0 || bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL mid_stale: got valid=%0b req=%0b expected 0 0", if_id.valid, bus.imem_req_o); end
      @(posedge clk); #1;
      bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h1234_5678;
      @(negedge clk);
      checks++; if (instr_o !== 32'h1234_5678) begin errors++; $display("FAIL mid_no_capture: got %h expected 12345678", instr_o); end
      stall_i = 1'b0;
      #1;
      checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== RPC) begin errors++; $display("FAIL mid_restart: got req=%0b addr=%h expected req=1 addr=%h", bus.imem_req_o, bus.imem_addr_o, RPC); end
      step();
   endtask

   task automatic test_misalign();
      instr_jalr_i = 1'b1; jalr_addr_i = 32'h202;
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL mis_redir_req: got %0b expected 0", bus.imem_req_o); end
      step();
      clear_redirects();
      @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
      checks++; if (fetch_misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag: got %0b expected 1", fetch_misalign_o); end
      checks++; if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h202 || if_id.valid !== 1'b0) begin errors++; $display("FAIL mis_halt: got req=%0b addr=%h valid=%0b expected 0 202 0", bus.imem_req_o, bus.imem_addr_o, if_id.valid); end
      step();
      @(negedge clk);
      checks++; if (bus.imem_req_o !== 1'b0 || fetch_misalign_o !== 1'b1) begin errors++; $display("FAIL mis_sticky: got req=%0b flag=%0b expected 0 1", bus.imem_req_o, fetch_misalign_o); end
`else
      checks++; if (bus.imem_addr_o !== 32'h200 || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL align_target: got req=%0b addr=%h expected req=1 addr=200", bus.imem_req_o, bus.imem_addr_o); end
`endif
      step();
   endtask

   task automatic test_random();
      logic        m_boot, m_valid, exp_req, redir;
      logic [31:0] m_pc, m_ifpc, tgt;
      rst_i = 1'b1; stall_i = 1'b0; clear_redirects();
      bus.imem_gnt_i = 1'b1; bus.imem_rvalid_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b0;
      m_boot = 1'b1; m_valid = 1'b0; m_pc = RPC; m_ifpc = '0;
      for (int n = 0; n < 400; n++) begin
         stall_i        = m_boot ? 1'b0 : ($urandom_range(3) == 0);
         bus.imem_gnt_i = ($urandom_range(3) != 0);
         instr_jalr_i   = ($urandom_range(11) == 0);
         instr_jal_i    = ($urandom_range(11) == 0);
         branch_taken_i = ($urandom_range(7) == 0);
         jalr_addr_i    = $urandom & ~32'd3;
         jal_addr_i     = $urandom & ~32'd3;
         branch_addr_i  = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'd3);
         redir   = instr_jalr_i | instr_jal_i | branch_taken_i;
         exp_req = !m_boot && !stall_i && !redir;
         @(negedge clk);
         checks++; if (bus.imem_req_o !== exp_req || bus.imem_addr_o !== m_pc) begin errors++; $display("FAIL rnd_req%0d: got req=%0b addr=%h expected req=%0b addr=%h", n, bus.imem_req_o, bus.imem_addr_o, exp_req, m_pc); end
         checks++; if (if_id.valid !== m_valid) begin errors++; $display("FAIL rnd_valid%0d: got %0b expected %0b", n, if_id.valid, m_valid); end
         if (m_valid) begin
            checks++; if (if_id.pc !== m_ifpc || if_id.pc_plus_four !== m_ifpc + 32'd4) begin errors++; $display("FAIL rnd_if_id%0d: got %h expected pc=%h", n, if_id, m_ifpc); end
            checks++; if (instr_o !== memw(m_ifpc)) begin errors++; $display("FAIL rnd_instr%0d: got %h expected %h", n, instr_o, memw(m_ifpc)); end
         end
         step();
         if (m_boot) begin
            m_boot = 1'b0;
         end else if (!stall_i) begin
            if (redir) begin
               tgt = instr_jalr_i ? jalr_addr_i : (instr_jal_i ? jal_addr_i : branch_addr_i);
               m_pc = tgt; m_valid = 1'b0;
            end else if (bus.imem_gnt_i) begin
               m_valid = 1'b1; m_ifpc = m_pc; m_pc = m_pc + 32'd4;
            end else begin
               m_valid = 1'b0;
            end
         end
      end
      clear_redirects(); stall_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_simultaneous();
      test_stall();
      test_gnt_wrap();
      test_reset_midflight();
      test_misalign();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
